pipo_load_arbiter: RTL and testbench

//   Round-robin arbiter and load sequencer for one shared PIPO register.
//   Up to NREQ requesters each present a WIDTH-bit word with a req line.
//   The block picks one winner, drives ld_en/ld_data into the PIPO register,

---
 rtl/pipo_load_arbiter_if.sv | 29 ++
 rtl/pipo_load_arbiter.sv | 155 +++++++++++++++
 tb/tb_pipo_load_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipo_load_arbiter_if.sv
// Requester-side bus of the PIPO load arbiter: request/data in, grant and load strobes out.
// Optional PIPO_ARB_GRANT_CNT_EN adds the grant_cnt observation signal.
interface pipo_load_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic [NREQ-1:0]       ack;
    logic                  ld_en;
    logic [WIDTH-1:0]      ld_data;
    logic [IDXW-1:0]       owner;
    logic                  busy;
`ifdef PIPO_ARB_GRANT_CNT_EN
    logic [7:0]            grant_cnt;

    modport master (output req, data_in,
                    input  ack, ld_en, ld_data, owner, busy, grant_cnt);
    modport slave  (input  req, data_in,
                    output ack, ld_en, ld_data, owner, busy, grant_cnt);
`else
    modport master (output req, data_in,
                    input  ack, ld_en, ld_data, owner, busy);
    modport slave  (input  req, data_in,
                    output ack, ld_en, ld_data, owner, busy);
`endif
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one shared PIPO register and then holds it stable.
// Optional feature macro: PIPO_ARB_GRANT_CNT_EN (8-bit wrapping count of LOAD cycles).
module pipo_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pipo_load_arbiter_if.slave    io_arb
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDXW-1:0]    r_rr_ptr;
    logic [IDXW-1:0]    w_rr_nxt;
    logic [3:0]         r_hold_cnt;
    logic [3:0]         w_hold_nxt;
    logic [NREQ-1:0]    r_ack;
    logic [NREQ-1:0]    w_ack_nxt;
    logic               r_ld_en;
    logic               w_ld_en_nxt;
    logic [WIDTH-1:0]   r_ld_data;
    logic [WIDTH-1:0]   w_ld_data_nxt;
    logic [IDXW-1:0]    r_owner;
    logic [IDXW-1:0]    w_owner_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_found;
    logic [IDXW-1:0]    w_win;
    logic [IDXW-1:0]    w_cand;

    // Round-robin search: first asserted req starting at r_rr_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr_ptr;
        w_cand  = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDXW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && io_arb.req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered so req never reaches them combinationally.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_ack_nxt     = {NREQ{1'b0}};
        w_ld_en_nxt   = 1'b0;
        w_ld_data_nxt = r_ld_data;
        w_owner_nxt   = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt   = ST_LOAD;
                    w_ack_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    w_ld_en_nxt   = 1'b1;
                    w_ld_data_nxt = io_arb.data_in[int'(w_win)*WIDTH +: WIDTH];
                    w_owner_nxt   = w_win;
                    w_rr_nxt      = (w_win == IDXW'(NREQ-1)) ? {IDXW{1'b0}} : w_win + {{(IDXW-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (HOLD_CYCLES > 0) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = 4'd1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 4'd0;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt >= 4'(HOLD_CYCLES)) begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = 4'd0;
                end else begin
                    w_hold_nxt  = r_hold_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 4'd0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // FSM state, round-robin pointer and hold counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= {IDXW{1'b0}};
            r_hold_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Registered outputs to the requesters and the PIPO register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ack     <= {NREQ{1'b0}};
            r_ld_en   <= 1'b0;
            r_ld_data <= {WIDTH{1'b0}};
            r_owner   <= {IDXW{1'b0}};
            r_busy    <= 1'b0;
        end else begin
            r_ack     <= w_ack_nxt;
            r_ld_en   <= w_ld_en_nxt;
            r_ld_data <= w_ld_data_nxt;
            r_owner   <= w_owner_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign io_arb.ack     = r_ack;
    assign io_arb.ld_en   = r_ld_en;
    assign io_arb.ld_data = r_ld_data;
    assign io_arb.owner   = r_owner;
    assign io_arb.busy    = r_busy;

`ifdef PIPO_ARB_GRANT_CNT_EN
    logic [7:0] r_grant_cnt;

    // Counts completed LOAD cycles, wrapping naturally at 8 bits.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant_cnt <= 8'd0;
        end else if (r_state == ST_LOAD) begin
            r_grant_cnt <= r_grant_cnt + 8'd1;
        end else begin
            r_grant_cnt <= r_grant_cnt;
        end
    end

    assign io_arb.grant_cnt = r_grant_cnt;
`endif
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed self-checking bench for pipo_load_arbiter (NREQ=4, WIDTH=4, HOLD_CYCLES=2).
module tb_pipo_load_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipo_load_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

    pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_arb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ack"},     32'(bus.ack),     32'd0);
        chk({tag, ".ld_en"},   32'(bus.ld_en),   32'd0);
        chk({tag, ".ld_data"}, 32'(bus.ld_data), 32'd0);
        chk({tag, ".owner"},   32'(bus.owner),   32'd0);
        chk({tag, ".busy"},    32'(bus.busy),    32'd0);
    endtask

    task automatic chk_load(input string tag, input logic [3:0] ack_e, input logic [3:0] data_e,
                            input logic [1:0] owner_e);
        chk({tag, ".ld_en"},   32'(bus.ld_en),   32'd1);
        chk({tag, ".ack"},     32'(bus.ack),     32'(ack_e));
        chk({tag, ".ld_data"}, 32'(bus.ld_data), 32'(data_e));
        chk({tag, ".owner"},   32'(bus.owner),   32'(owner_e));
        chk({tag, ".busy"},    32'(bus.busy),    32'd1);
    endtask

    logic [3:0] exp_d [0:4];
    logic [1:0] exp_o [0:4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_d   = '{4'b1000, 4'b1010, 4'b1100, 4'b1110, 4'b1000};
        exp_o   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset held with all requests high.
        rst         = 1'b0;
        bus.req     = 4'b1111;
        bus.data_in = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("rst");
        end
`ifdef PIPO_ARB_GRANT_CNT_EN
        chk("rst.grant_cnt", 32'(bus.grant_cnt), 32'd0);
`endif

        // Single request from requester 2.
        bus.req     = 4'b0100;
        bus.data_in = 16'h0600;
        rst         = 1'b1;
        tick();
        chk_load("single", 4'b0100, 4'b0110, 2'd2);
        bus.req     = 4'b0000;
        bus.data_in = 16'h0F00;
        #1;
        chk("single.data_stable", 32'(bus.ld_data), 32'h6);
        tick();
        chk("single.h1.busy", 32'(bus.busy), 32'd1);
        chk("single.h1.ld_en", 32'(bus.ld_en), 32'd0);
        chk("single.h1.ack", 32'(bus.ack), 32'd0);
        tick();
        chk("single.h2.busy", 32'(bus.busy), 32'd1);
        tick();
        chk("single.idle.busy", 32'(bus.busy), 32'd0);

        // Fresh pointer, all requesters held: strict rotation every 4 cycles.
        rst = 1'b0;
        #1;
        rst         = 1'b1;
        bus.req     = 4'b1111;
        bus.data_in = 16'b1110_1100_1010_1000;
        tick();
        chk_load("rr0", 4'b0001, exp_d[0], exp_o[0]);
        for (int n = 1; n < 5; n++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("rr.gap.ld_en", 32'(bus.ld_en), 32'd0);
            end
            tick();
            chk_load("rr", 4'(1 << exp_o[n]), exp_d[n], exp_o[n]);
        end
        bus.req = 4'b0000;
        tick();
        tick();
        tick();

        // Reset during the first HOLD cycle; rr_ptr must return to 0.
        bus.req = 4'b0100;
        tick();
        chk_load("pre_abort", 4'b0100, 4'b1100, 2'd2);
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        chk_all_zero("abort");
        rst     = 1'b1;
        bus.req = 4'b1010;
        tick();
        chk_load("post_abort", 4'b0010, 4'b1010, 2'd1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        chk("post_abort.idle.busy", 32'(bus.busy), 32'd0);

        // Request pulsed only during HOLD is ignored.
        bus.req = 4'b0001;
        tick();
        chk_load("pulse.load", 4'b0001, 4'b1000, 2'd0);
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1000;
        tick();
        chk("pulse.h2.ack", 32'(bus.ack), 32'd0);
        bus.req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("pulse.ack", 32'(bus.ack), 32'd0);
            chk("pulse.ld_en", 32'(bus.ld_en), 32'd0);
            chk("pulse.busy", 32'(bus.busy), 32'd0);
        end

`ifdef PIPO_ARB_GRANT_CNT_EN
        // 257 loads wrap the 8-bit counter to 1.
        begin
            int loads;
            int cyc;
            rst = 1'b0;
            #1;
            rst     = 1'b1;
            bus.req = 4'b1111;
            loads   = 0;
            cyc     = 0;
            while (loads < 257 && cyc < 2000) begin
                tick();
                cyc++;
                if (bus.ld_en === 1'b1) loads++;
            end
            chk("gcnt.loads", 32'(loads), 32'd257);
            bus.req = 4'b0000;
            tick();
            chk("gcnt.value", 32'(bus.grant_cnt), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
